// File: rtl/pmc_ac_loader_pkg.sv
// Shared types and sizing helpers for the analog-config loader.
package pmc_ac_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_DONE
    } pmc_ac_loader_state_t;

    // Word index covers up to 16 config words.
    localparam int IDX_W = 4;

    // Counter width able to hold TIMEOUT.
    function automatic int tmo_cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ibex_data_bus.sv
// Simple req/gnt/rvalid data bus shared by the core and the loader.
interface ibex_data_bus;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/pmc_ac_loader_timer.sv
// Per-transaction watchdog: counts while enabled, flags when TIMEOUT cycles elapse.
module pmc_ac_loader_timer
    import pmc_ac_loader_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = tmo_cnt_width(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Count cycles spent in the current bus state; restart on every state entry.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pmc_ac_loader.sv
// Bus initiator: writes a config image to the analog register bank, then optionally reads it back.
module pmc_ac_loader
    import pmc_ac_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          NUM_WORDS = 4,
    parameter bit          VERIFY    = 1'b1,
    parameter int          TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [32*NUM_WORDS-1:0] cfg,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [3:0]              err_idx,
    ibex_data_bus.master            data_bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    pmc_ac_loader_state_t r_state, w_next;
    logic [IDX_W-1:0]     r_idx, w_next_idx;
    logic                 r_err_flag, w_next_err_flag;
    logic [IDX_W-1:0]     r_err_pos, w_next_err_pos;
    logic [32*NUM_WORDS-1:0] r_shadow;

    logic        w_accept;
    logic        w_tmo_hit;
    logic        w_expired;
    logic        w_in_bus;
    logic        w_next_req;
    logic [31:0] w_cur_word;
    logic [31:0] w_next_word;

    logic        r_req, r_we, r_busy, r_done, r_err;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_err_idx;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_in_bus    = (r_state == ST_WR_REQ) || (r_state == ST_WR_RSP) ||
                         (r_state == ST_RD_REQ) || (r_state == ST_RD_RSP);
    assign w_cur_word  = r_shadow[32*r_idx +: 32];
    // The shadow is loaded on the accepting edge, so word 0 comes straight from cfg then.
    assign w_next_word = (r_state == ST_IDLE) ? cfg[31:0] : r_shadow[32*w_next_idx +: 32];
    assign w_next_req  = (w_next == ST_WR_REQ) || (w_next == ST_RD_REQ);

    pmc_ac_loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_next != r_state),
        .i_enable  (w_in_bus),
        .o_expired (w_expired)
    );

    // Next-state, word index and error tracking.
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        w_next          = r_state;
        w_next_idx      = r_idx;
        w_next_err_flag = r_err_flag;
        w_next_err_pos  = r_err_pos;
        w_tmo_hit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next          = ST_WR_REQ;
                    w_next_idx      = '0;
                    w_next_err_flag = 1'b0;
                    w_next_err_pos  = '0;
                end
            end
            ST_WR_REQ: begin
                if (data_bus.gnt)   w_next = ST_WR_RSP;
                else if (w_expired) w_tmo_hit = 1'b1;
            end
            ST_WR_RSP: begin
                if (data_bus.rvalid) begin
                    if (r_idx == LAST_IDX) begin
                        w_next_idx = '0;
                        w_next     = VERIFY ? ST_RD_REQ : ST_DONE;
                    end else begin
                        w_next_idx = r_idx + 1'b1;
                        w_next     = ST_WR_REQ;
                    end
                end else if (w_expired) begin
                    w_tmo_hit = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (data_bus.gnt)   w_next = ST_RD_RSP;
                else if (w_expired) w_tmo_hit = 1'b1;
            end
            ST_RD_RSP: begin
                if (data_bus.rvalid) begin
                    if ((data_bus.rdata != w_cur_word) && !r_err_flag) begin
                        w_next_err_flag = 1'b1;
                        w_next_err_pos  = r_idx;
                    end
                    if (r_idx == LAST_IDX) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next_idx = r_idx + 1'b1;
                        w_next     = ST_RD_REQ;
                    end
                end else if (w_expired) begin
                    w_tmo_hit = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (w_tmo_hit) begin
            w_next          = ST_DONE;
            w_next_err_flag = 1'b1;
            if (!r_err_flag) w_next_err_pos = r_idx;
        end
    end

    // State register and registered bus/status outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_err_flag <= 1'b0;
            r_err_pos  <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_idx  <= '0;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_next_idx;
            r_err_flag <= w_next_err_flag;
            r_err_pos  <= w_next_err_pos;
            r_req      <= w_next_req;
            r_we       <= (w_next == ST_WR_REQ);
            if (w_next_req) begin
                r_addr <= BASE_ADDR + {{(30-IDX_W){1'b0}}, w_next_idx, 2'b00};
            end
            if (w_next == ST_WR_REQ) begin
                r_wdata <= w_next_word;
            end
            r_busy <= (w_next != ST_IDLE);
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_err     <= 1'b0;
                r_err_idx <= '0;
            end else if (r_state == ST_DONE) begin
                r_err     <= r_err_flag;
                r_err_idx <= r_err_pos;
            end
        end
    end

    // Capture the config image so later cfg changes cannot disturb a run.
    // NOTE: the shadow is pure data qualified by the FSM, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) r_shadow <= cfg;
    end

    assign data_bus.req   = r_req;
    assign data_bus.we    = r_we;
    assign data_bus.addr  = r_addr;
    assign data_bus.wdata = r_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign err_idx        = r_err_idx;

endmodule

// File: tb/tb_pmc_ac_loader.sv
// Self-checking bench for pmc_ac_loader with a configurable bus slave and a transaction scoreboard.
module tb_pmc_ac_loader;

    localparam int NW = 4;
    localparam logic [127:0] CFG_A = 128'h01234567_76543210_FEDCBA98_89ABCDEF;
    localparam logic [127:0] CFG_B = 128'hDEADBEEF_CAFEF00D_A5A5A5A5_5A5A5A5A;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cfg;
    logic         busy, done, err;
    logic [3:0]   err_idx;

    int n_cmp = 0;
    int n_mis = 0;

    txn_t exp_q[$];

    // Slave behaviour knobs.
    int          delay_word = -1;
    int          delay_len  = 0;
    bit          never_gnt  = 1'b0;
    logic [15:0] corrupt    = '0;
    logic [31:0] mem [16];
    int          wait_cnt;

    ibex_data_bus bus ();

    pmc_ac_loader #(
        .BASE_ADDR (32'h0),
        .NUM_WORDS (NW),
        .VERIFY    (1'b1),
        .TIMEOUT   (255)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg      (cfg),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx),
        .data_bus (bus)
    );

    always #5 clk = ~clk;

    // Grant combinationally, optionally after a write-only delay on one word.
    assign bus.gnt = bus.req && !never_gnt &&
                     (wait_cnt >= ((bus.we && int'(bus.addr[5:2]) == delay_word) ? delay_len : 0));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= 0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            wait_cnt   <= (bus.req && !bus.gnt) ? wait_cnt + 1 : 0;
            bus.rvalid <= bus.req && bus.gnt;
            if (bus.req && bus.gnt) begin
                if (bus.we) mem[bus.addr[5:2]] <= bus.wdata;
                bus.rdata <= mem[bus.addr[5:2]] ^ {31'd0, corrupt[bus.addr[5:2]]};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic slave_defaults();
        delay_word = -1;
        delay_len  = 0;
        never_gnt  = 1'b0;
        corrupt    = '0;
        exp_q.delete();
    endtask

    task automatic push_expected(input logic [127:0] c);
        txn_t t;
        for (int i = 0; i < NW; i++) begin
            t.we = 1'b1; t.addr = 32'(4*i); t.data = c[32*i +: 32];
            exp_q.push_back(t);
        end
        for (int i = 0; i < NW; i++) begin
            t.we = 1'b0; t.addr = 32'(4*i); t.data = c[32*i +: 32];
            exp_q.push_back(t);
        end
    endtask

    // Start a load, then monitor the bus each cycle until done (plus a short tail) or the budget runs out.
    task automatic run_load(input logic [127:0] c, input int max_cyc, input int poke_cyc,
                            output int done_cyc, output int done_cnt, output int req_cyc);
        int          cyc;
        bit          pend;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        txn_t        t;
        done_cyc = -1; done_cnt = 0; req_cyc = 0; pend = 1'b0;
        h_addr = '0; h_wdata = '0; h_we = 1'b0;
        @(negedge clk);
        cfg   = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < max_cyc && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            start = (cyc == poke_cyc);
            if (cyc == poke_cyc) cfg = CFG_B;
            if (bus.req) begin
                req_cyc++;
                if (pend) begin
                    n_cmp++;
                    if (bus.addr !== h_addr || bus.wdata !== h_wdata || bus.we !== h_we) begin
                        n_mis++;
                        $display("FAIL hold_stable cyc=%0d: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                                 cyc, bus.we, bus.addr, bus.wdata, h_we, h_addr, h_wdata);
                    end
                end
            end
            if (bus.req && bus.gnt) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_txn cyc=%0d: got we=%b addr=%h, want none", cyc, bus.we, bus.addr);
                end else begin
                    t = exp_q.pop_front();
                    if (bus.we !== t.we || bus.addr !== t.addr || (t.we && bus.wdata !== t.data)) begin
                        n_mis++;
                        $display("FAIL txn cyc=%0d: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                                 cyc, bus.we, bus.addr, bus.wdata, t.we, t.addr, t.data);
                    end
                end
            end
            pend    = bus.req && !bus.gnt;
            h_addr  = bus.addr;
            h_wdata = bus.wdata;
            h_we    = bus.we;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (done_cyc < 0) begin
            n_mis++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_left: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic check_end(input string name, input int dcyc, input int dcnt, input int want_cyc,
                             input logic want_err, input logic [3:0] want_idx);
        n_cmp++;
        if (dcyc != want_cyc) begin
            n_mis++;
            $display("FAIL %s_done_cycle: got %0d, want %0d", name, dcyc, want_cyc);
        end
        n_cmp++;
        if (dcnt != 1) begin
            n_mis++;
            $display("FAIL %s_done_pulses: got %0d, want 1", name, dcnt);
        end
        n_cmp++;
        if (err !== want_err || err_idx !== want_idx) begin
            n_mis++;
            $display("FAIL %s_err: got err=%b idx=%0d, want err=%b idx=%0d", name, err, err_idx, want_err, want_idx);
        end
        n_cmp++;
        if (busy !== 1'b0 || bus.req !== 1'b0) begin
            n_mis++;
            $display("FAIL %s_idle: got busy=%b req=%b, want 0/0", name, busy, bus.req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.req, bus.we, busy, done, err} !== 5'b0 || bus.addr !== '0 || bus.wdata !== '0 || err_idx !== '0) begin
            n_mis++;
            $display("FAIL reset_values: got req=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b idx=%0d, want all 0",
                     bus.req, bus.we, bus.addr, bus.wdata, busy, done, err, err_idx);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.req !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL idle_after_reset: got req=%b busy=%b, want 0/0", bus.req, busy);
        end
    endtask

    task automatic test_zero_wait();
        int dc, dn, rc;
        slave_defaults();
        push_expected(CFG_A);
        run_load(CFG_A, 100, -1, dc, dn, rc);
        check_end("zero_wait", dc, dn, 17, 1'b0, 4'd0);
    endtask

    task automatic test_gnt_delay();
        int dc, dn, rc;
        slave_defaults();
        delay_word = 2; delay_len = 3;
        push_expected(CFG_A);
        run_load(CFG_A, 100, -1, dc, dn, rc);
        check_end("gnt_delay", dc, dn, 20, 1'b0, 4'd0);
    endtask

    task automatic test_corrupt();
        int dc, dn, rc;
        slave_defaults();
        corrupt = 16'b1010;
        push_expected(CFG_B);
        run_load(CFG_B, 100, -1, dc, dn, rc);
        check_end("corrupt", dc, dn, 17, 1'b1, 4'd1);
    endtask

    task automatic test_timeout();
        int dc, dn, rc;
        slave_defaults();
        never_gnt = 1'b1;
        run_load(CFG_A, 400, -1, dc, dn, rc);
        n_cmp++;
        if (rc != 255) begin
            n_mis++;
            $display("FAIL timeout_req_cycles: got %0d, want 255", rc);
        end
        check_end("timeout", dc, dn, 256, 1'b1, 4'd0);
        never_gnt = 1'b0;
    endtask

    task automatic test_restart_ignored();
        int dc, dn, rc;
        slave_defaults();
        push_expected(CFG_A);
        run_load(CFG_A, 100, 3, dc, dn, rc);
        check_end("restart", dc, dn, 17, 1'b0, 4'd0);
    endtask

    task automatic test_reset_midrun();
        int dc, dn, rc;
        slave_defaults();
        @(negedge clk);
        cfg = CFG_A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1 || bus.addr !== 32'h8) begin
            n_mis++;
            $display("FAIL midrun_state: got busy=%b addr=%h, want 1/00000008", busy, bus.addr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || bus.req !== 1'b0 || bus.addr !== '0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL async_reset: got busy=%b req=%b addr=%h done=%b, want 0/0/0/0", busy, bus.req, bus.addr, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_expected(CFG_A);
        run_load(CFG_A, 100, -1, dc, dn, rc);
        check_end("after_reset", dc, dn, 17, 1'b0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_gnt_delay();
        test_corrupt();
        test_timeout();
        test_restart_ignored();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pmc_ac_loader.md
# pmc_ac_loader

Bus initiator that pushes a complete pixel-matrix analog configuration into the analog-config register bank over `ibex_data_bus`, then reads it back to verify it. It sits beside the core as a second master on the peripheral bus path. On `start`, it writes NUM_WORDS consecutive 32-bit words from a parallel `cfg` vector to BASE_ADDR, BASE_ADDR+4, and so on. It reports completion and any mismatch or timeout.

## Interface
- BASE_ADDR, 32'h0, byte address of config word 0
- NUM_WORDS, 4, number of 32-bit words (1..16)
- VERIFY, 1, 1 = readback and compare after writes; 0 = writes only
- TIMEOUT, 255, max cycles waited for `gnt` or `rvalid` per transaction
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a load; sampled only in IDLE
- cfg  input  32*NUM_WORDS  config image; word i = cfg[32*i+31:32*i]
- busy  output  1  high from the cycle after `start` is accepted until `done`
- done  output  1  one-cycle pulse at end of run
- err  output  1  set at end of run if any mismatch or timeout; held until next accepted `start`
- err_idx  output  4  index of first failing word
- data_bus  ibex_data_bus.master  —  drives req, we, addr, wdata; samples gnt, rvalid, rdata

## Operation
- States: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE.
- IDLE + `start`:
  - latch `cfg` into a shadow register
  - clear `err`/`err_idx` and the word index
  - go to WR_REQ
- WR_REQ:
  - drive req=1, we=1, addr=BASE_ADDR+4*idx, wdata=shadow[idx]
  - hold all of these stable until `gnt`, then go to WR_RSP
- WR_RSP: wait for `rvalid`.
  - If idx<NUM_WORDS-1: idx++ and return to WR_REQ.
  - Otherwise: idx=0, go to RD_REQ if VERIFY, else DONE.
- RD_REQ: as WR_REQ with we=0; on `gnt`, go to RD_RSP.
- RD_RSP: on `rvalid`, compare rdata with shadow[idx].
  - On the first mismatch, set the error flag and err_idx=idx.
  - Continue through all words regardless.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Timeout: a per-transaction counter clears on each state entry and counts in *_REQ/*_RSP.
  - On reaching TIMEOUT: set the error flag (and err_idx if it is the first error), drop req, go to DONE.
- Only one transaction is outstanding at a time. req is never asserted in *_RSP states.
- `start` while not IDLE is ignored. `cfg` changes after acceptance have no effect.
- `rvalid` seen outside *_RSP is ignored.
- `gnt` without req is ignored.

## Timing
- Reset values: req=0, we=0, addr=0, wdata=0, busy=0, done=0, err=0, err_idx=0, state IDLE. An asserted `rst` drops req asynchronously mid-transaction.
- All outputs are registered. req rises the cycle after `start` is sampled.
- `gnt` in the same cycle req is high completes the request phase. Earliest `rvalid` is the cycle after `gnt`.
- Zero-wait slave (gnt immediate, rvalid next cycle): 2 cycles per word. `done` pulses 2*NUM_WORDS*(1+VERIFY)+1 cycles after the `start` edge (17 for the defaults).
- `err` becomes valid in the same cycle as `done`.

## Structure
- pmc_ac_loader_pkg:
  - state enum pmc_ac_loader_state_t
  - word-index width constant
  - timeout counter width derived from TIMEOUT
- Sub-module pmc_ac_loader_timer: clear/enable inputs, `expired` output, TIMEOUT parameter.
- Compare logic and the address generator stay in the top module.

## Test plan
- Zero-wait slave, cfg=128'h0123…CDEF, VERIFY=1 → 4 writes to 0x0/0x4/0x8/0xC with matching wdata, 4 reads; done at cycle 17; err=0.
- Slave delays `gnt` 3 cycles on word 2 → addr/wdata/we held stable throughout; run completes with err=0, done at cycle 20.
- Slave corrupts readback of word 1 (rdata^32'h1) and word 3 → err=1, err_idx=1, done pulses once.
- Slave never asserts `gnt` on word 0 → req drops after 255 cycles; done pulses; err=1; err_idx=0; busy=0.
- `start` re-pulsed mid-run plus `cfg` changed → ignored; written data equals the originally latched image.
- `rst` asserted during WR_RSP of word 2 → req/busy go 0 immediately; a subsequent `start` runs a clean full load from word 0.
